// File: rtl/core_apb_dec.sv
// APB address decoder: one upstream master fanned out to NSLV slaves selected by an address field.
// Optional access-phase timeout is enabled by defining CORE_APB_DEC_TOUT_EN.
module core_apb_dec #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int NSLV     = 2,
  parameter int DEC_LSB  = 27,
  parameter int DEC_W    = 1,
  parameter int TOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_psel,
  input  logic               m_penable,
  input  logic               m_pwrite,
  input  logic [AW-1:0]      m_paddr,
  input  logic [DW/8-1:0]    m_pstrb,
  input  logic [2:0]         m_pprot,
  input  logic [DW-1:0]      m_pwdata,
  output logic [DW-1:0]      m_prdata,
  output logic               m_pslverr,
  output logic               m_pready,
  output logic [NSLV-1:0]    s_psel,
  output logic [NSLV-1:0]    s_penable,
  output logic [AW-1:0]      s_paddr,
  output logic               s_pwrite,
  output logic [DW/8-1:0]    s_pstrb,
  output logic [2:0]         s_pprot,
  output logic [DW-1:0]      s_pwdata,
  input  logic [NSLV*DW-1:0] s_prdata,
  input  logic [NSLV-1:0]    s_pslverr,
  input  logic [NSLV-1:0]    s_pready
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  function automatic logic is_mapped(input logic [DEC_W-1:0] v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      hit = hit | (v == DEC_W'(i));
    end
    return hit;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [DEC_W-1:0] sel_q, sel_d;
  logic [DEC_W-1:0] idx_s;
  logic             sel_map_s;
  logic             sel_ready_s;
  logic             sel_err_s;
  logic [DW-1:0]    sel_rdata_s;
  logic             access_s;
  logic             viol_s;
  logic             abort_s;

  assign idx_s     = m_paddr[DEC_LSB +: DEC_W];
  assign sel_map_s = is_mapped(sel_q);
  assign access_s  = (state_q == ST_ACCESS) & m_psel & m_penable;
  assign viol_s    = (state_q == ST_IDLE) & m_penable;

  assign s_paddr  = m_paddr;
  assign s_pwrite = m_pwrite;
  assign s_pstrb  = m_pstrb;
  assign s_pprot  = m_pprot;
  assign s_pwdata = m_pwdata;

  // Response mux driven only by the slave index latched at the start of the access
  always_comb begin
    sel_ready_s = 1'b0;
    sel_err_s   = 1'b0;
    sel_rdata_s = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == DEC_W'(i)) begin
        sel_ready_s = s_pready[i];
        sel_err_s   = s_pslverr[i];
        sel_rdata_s = s_prdata[i*DW +: DW];
      end else begin
        sel_ready_s = sel_ready_s;
      end
    end
  end

`ifdef CORE_APB_DEC_TOUT_EN
  localparam int CW = $clog2(TOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign abort_s = (state_q == ST_ACCESS) & m_psel & (cnt_q == CW'(TOUT_CYC));

  // Wait counter: counts stalled access cycles of a mapped slave, cleared whenever idle
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ST_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (access_s & sel_map_s & ~sel_ready_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Wait counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign abort_s = 1'b0;
`endif

  // Per-slave select/enable; a setup cycle with penable already high selects nothing
  always_comb begin
    s_psel    = '0;
    s_penable = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (rst) begin
        s_psel[i]    = 1'b0;
        s_penable[i] = 1'b0;
      end else if (state_q == ST_IDLE) begin
        s_psel[i]    = m_psel & ~m_penable & (idx_s == DEC_W'(i));
        s_penable[i] = 1'b0;
      end else begin
        s_psel[i]    = m_psel & (sel_q == DEC_W'(i)) & ~abort_s;
        s_penable[i] = s_psel[i] & m_penable;
      end
    end
  end

  // Upstream response: errors for protocol violation, unmapped index or timeout
  always_comb begin
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    m_prdata  = '0;
    if (rst) begin
      m_pready = 1'b0;
    end else if (viol_s) begin
      m_pready  = 1'b1;
      m_pslverr = 1'b1;
    end else if (access_s) begin
      if (abort_s | ~sel_map_s) begin
        m_pready  = 1'b1;
        m_pslverr = 1'b1;
      end else if (sel_ready_s) begin
        m_pready  = 1'b1;
        m_pslverr = sel_err_s;
        m_prdata  = sel_rdata_s;
      end else begin
        m_pready = 1'b0;
      end
    end else begin
      m_pready = 1'b0;
    end
  end

  // Transfer FSM next state
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (m_psel & ~m_penable) begin
          state_d = ST_ACCESS;
          sel_d   = idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (~m_psel | m_pready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and latched slave index
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_core_apb_dec.sv
// Directed bench for core_apb_dec: default 2-slave instance plus a 3-slave, 2-bit-index instance.
module tb_core_apb_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_psel, m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata;
  logic [3:0]  m_pstrb;
  logic [2:0]  m_pprot;

  logic [31:0] a_prdata;
  logic        a_pslverr, a_pready;
  logic [1:0]  a_psel, a_penable;
  logic [31:0] a_paddr, a_pwdata;
  logic        a_pwrite;
  logic [3:0]  a_pstrb;
  logic [2:0]  a_pprot;
  logic [63:0] a_s_prdata;
  logic [1:0]  a_s_pslverr, a_s_pready;

  logic [31:0] b_prdata;
  logic        b_pslverr, b_pready;
  logic [2:0]  b_psel, b_penable;
  logic [31:0] b_paddr, b_pwdata;
  logic        b_pwrite;
  logic [3:0]  b_pstrb;
  logic [2:0]  b_pprot;
  logic [95:0] b_s_prdata;
  logic [2:0]  b_s_pslverr, b_s_pready;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  core_apb_dec u_a (
    .clk(clk), .rst(rst),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pstrb(m_pstrb), .m_pprot(m_pprot), .m_pwdata(m_pwdata),
    .m_prdata(a_prdata), .m_pslverr(a_pslverr), .m_pready(a_pready),
    .s_psel(a_psel), .s_penable(a_penable), .s_paddr(a_paddr), .s_pwrite(a_pwrite),
    .s_pstrb(a_pstrb), .s_pprot(a_pprot), .s_pwdata(a_pwdata),
    .s_prdata(a_s_prdata), .s_pslverr(a_s_pslverr), .s_pready(a_s_pready)
  );

  core_apb_dec #(.NSLV(3), .DEC_W(2), .TOUT_CYC(4)) u_b (
    .clk(clk), .rst(rst),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pstrb(m_pstrb), .m_pprot(m_pprot), .m_pwdata(m_pwdata),
    .m_prdata(b_prdata), .m_pslverr(b_pslverr), .m_pready(b_pready),
    .s_psel(b_psel), .s_penable(b_penable), .s_paddr(b_paddr), .s_pwrite(b_pwrite),
    .s_pstrb(b_pstrb), .s_pprot(b_pprot), .s_pwdata(b_pwdata),
    .s_prdata(b_s_prdata), .s_pslverr(b_s_pslverr), .s_pready(b_s_pready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then inputs may change
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic sel, input logic en, input logic [31:0] addr);
    m_psel    = sel;
    m_penable = en;
    m_paddr   = addr;
  endtask

  initial begin
    rst = 1'b1;
    m_pwrite = 1'b0; m_pwdata = 32'h0; m_pstrb = 4'h0; m_pprot = 3'h0;
    drive(1'b1, 1'b1, 32'h0000_0010);
    a_s_pready = 2'b11; a_s_pslverr = 2'b11; a_s_prdata = {32'h1111_2222, 32'h3333_4444};
    b_s_pready = 3'b111; b_s_pslverr = 3'b000; b_s_prdata = {32'h7777_0002, 32'h7777_0001, 32'h7777_0000};

    // Reset forces outputs low regardless of inputs
    cyc(); settle();
    chk("rst_psel", {62'd0, a_psel}, 64'd0);
    chk("rst_penable", {62'd0, a_penable}, 64'd0);
    chk("rst_pready", {63'd0, a_pready}, 64'd0);
    chk("rst_pslverr", {63'd0, a_pslverr}, 64'd0);
    chk("rst_prdata", {32'd0, a_prdata}, 64'd0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    a_s_pslverr = 2'b00;

    // Read slave0, ready in first access cycle
    cyc(); drive(1'b1, 1'b0, 32'h0000_0010); settle();
    chk("rd0_setup_psel", {62'd0, a_psel}, 64'h1);
    chk("rd0_setup_pready", {63'd0, a_pready}, 64'd0);
    cyc(); m_penable = 1'b1; a_s_pready = 2'b01;
    a_s_prdata = {32'hDEAD_BEEF, 32'hA5A5_0001}; settle();
    chk("rd0_psel", {62'd0, a_psel}, 64'h1);
    chk("rd0_penable", {62'd0, a_penable}, 64'h1);
    chk("rd0_prdata", {32'd0, a_prdata}, 64'hA5A5_0001);
    chk("rd0_pready", {63'd0, a_pready}, 64'h1);
    chk("rd0_pslverr", {63'd0, a_pslverr}, 64'd0);

    // Back-to-back write to slave1 with 3 wait states; slave0 ready must be ignored
    cyc(); drive(1'b1, 1'b0, 32'h0800_0004);
    m_pwrite = 1'b1; m_pwdata = 32'h1234_5678; m_pstrb = 4'b0101; m_pprot = 3'b010;
    a_s_pready = 2'b00; settle();
    chk("wr1_setup_psel", {62'd0, a_psel}, 64'h2);
    chk("wr1_pwdata", {32'd0, a_pwdata}, 64'h1234_5678);
    chk("wr1_pstrb", {60'd0, a_pstrb}, 64'h5);
    chk("wr1_paddr", {32'd0, a_paddr}, 64'h0800_0004);
    chk("wr1_pwrite", {63'd0, a_pwrite}, 64'h1);
    chk("wr1_pprot", {61'd0, a_pprot}, 64'h2);
    for (int k = 0; k < 4; k++) begin
      cyc(); m_penable = 1'b1;
      a_s_pready = (k == 3) ? 2'b10 : 2'b01;
      settle();
      chk("wr1_pready", {63'd0, a_pready}, (k == 3) ? 64'h1 : 64'h0);
      chk("wr1_penable", {62'd0, a_penable}, 64'h2);
    end

    // Slave error and read data pass through from slave1
    cyc(); drive(1'b1, 1'b0, 32'h0800_0000); m_pwrite = 1'b0;
    cyc(); m_penable = 1'b1; a_s_pready = 2'b10; a_s_pslverr = 2'b10;
    a_s_prdata = {32'hCAFE_F00D, 32'h0000_0BAD}; settle();
    chk("err1_pslverr", {63'd0, a_pslverr}, 64'h1);
    chk("err1_prdata", {32'd0, a_prdata}, 64'hCAFE_F00D);
    chk("err1_pready", {63'd0, a_pready}, 64'h1);
    a_s_pslverr = 2'b00;

    cyc(); drive(1'b0, 1'b0, 32'h0); settle();
    chk("idle_pready", {63'd0, a_pready}, 64'd0);
    chk("idle_psel", {62'd0, a_psel}, 64'd0);

    // penable high while idle is a protocol violation
    cyc(); drive(1'b1, 1'b1, 32'h0000_0010); a_s_pready = 2'b11; settle();
    chk("viol_psel", {62'd0, a_psel}, 64'd0);
    chk("viol_pready", {63'd0, a_pready}, 64'h1);
    chk("viol_pslverr", {63'd0, a_pslverr}, 64'h1);
    chk("viol_prdata", {32'd0, a_prdata}, 64'd0);

    // psel dropped mid-access: no response, back to idle
    cyc(); drive(1'b1, 1'b0, 32'h0000_0010); a_s_pready = 2'b00;
    cyc(); m_penable = 1'b1; settle();
    chk("drop_wait_pready", {63'd0, a_pready}, 64'd0);
    cyc(); drive(1'b0, 1'b0, 32'h0000_0010); a_s_pready = 2'b11; settle();
    chk("drop_pready", {63'd0, a_pready}, 64'd0);
    chk("drop_psel", {62'd0, a_psel}, 64'd0);
    cyc(); drive(1'b1, 1'b0, 32'h0800_0000); settle();
    chk("drop_next_setup_psel", {62'd0, a_psel}, 64'h2);
    cyc(); m_penable = 1'b1; a_s_pready = 2'b10; settle();
    chk("drop_next_pready", {63'd0, a_pready}, 64'h1);

    // Reset in second wait cycle of a slave1 access
    cyc(); drive(1'b1, 1'b0, 32'h0800_0000); a_s_pready = 2'b00;
    cyc(); m_penable = 1'b1;
    cyc(); rst = 1'b1; a_s_pready = 2'b11; a_s_pslverr = 2'b11; settle();
    chk("rstmid_psel", {62'd0, a_psel}, 64'd0);
    chk("rstmid_penable", {62'd0, a_penable}, 64'd0);
    chk("rstmid_pready", {63'd0, a_pready}, 64'd0);
    chk("rstmid_pslverr", {63'd0, a_pslverr}, 64'd0);
    chk("rstmid_prdata", {32'd0, a_prdata}, 64'd0);
    cyc(); rst = 1'b0; drive(1'b1, 1'b0, 32'h0000_0020); a_s_pslverr = 2'b00; settle();
    chk("rstpost_setup_psel", {62'd0, a_psel}, 64'h1);
    chk("rstpost_setup_penable", {62'd0, a_penable}, 64'd0);
    cyc(); m_penable = 1'b1; a_s_pready = 2'b01; a_s_prdata = {32'h0, 32'h0000_5A5A}; settle();
    chk("rstpost_pready", {63'd0, a_pready}, 64'h1);
    chk("rstpost_pslverr", {63'd0, a_pslverr}, 64'd0);
    chk("rstpost_prdata", {32'd0, a_prdata}, 64'h5A5A);

    // Unresponsive slave stalls the default instance
    cyc(); drive(1'b1, 1'b0, 32'h0000_0000); a_s_pready = 2'b00;
    for (int k = 0; k < 20; k++) begin
      cyc(); m_penable = 1'b1;
    end
    settle();
    chk("stall_pready", {63'd0, a_pready}, 64'd0);
    chk("stall_psel", {62'd0, a_psel}, 64'h1);
    cyc(); a_s_pready = 2'b01; settle();
    chk("stall_release_pready", {63'd0, a_pready}, 64'h1);
    a_s_pready = 2'b11;

    // Three-slave instance: index 3 unmapped, index 2 mapped
    cyc(); drive(1'b0, 1'b0, 32'h0);
    cyc(); drive(1'b1, 1'b0, 32'h1800_0000);
    b_s_prdata = {32'h7777_0002, 32'h7777_0001, 32'h7777_0000}; settle();
    chk("unm_setup_psel", {61'd0, b_psel}, 64'd0);
    chk("unm_setup_pready", {63'd0, b_pready}, 64'd0);
    cyc(); m_penable = 1'b1; settle();
    chk("unm_psel", {61'd0, b_psel}, 64'd0);
    chk("unm_pready", {63'd0, b_pready}, 64'h1);
    chk("unm_pslverr", {63'd0, b_pslverr}, 64'h1);
    chk("unm_prdata", {32'd0, b_prdata}, 64'd0);
    cyc(); drive(1'b1, 1'b0, 32'h1000_0008); settle();
    chk("s2_setup_psel", {61'd0, b_psel}, 64'h4);
    cyc(); m_penable = 1'b1; settle();
    chk("s2_prdata", {32'd0, b_prdata}, 64'h7777_0002);
    chk("s2_pslverr", {63'd0, b_pslverr}, 64'd0);

`ifdef CORE_APB_DEC_TOUT_EN
    // Timeout after TOUT_CYC=4 stalled cycles, then a normal transfer to slave1
    cyc(); drive(1'b1, 1'b0, 32'h0000_0010); b_s_pready = 3'b000;
    for (int k = 0; k < 5; k++) begin
      cyc(); m_penable = 1'b1; settle();
      chk("tout_pready", {63'd0, b_pready}, (k == 4) ? 64'h1 : 64'h0);
      chk("tout_psel0", {63'd0, b_psel[0]}, (k == 4) ? 64'h0 : 64'h1);
    end
    chk("tout_pslverr", {63'd0, b_pslverr}, 64'h1);
    chk("tout_prdata", {32'd0, b_prdata}, 64'd0);
    cyc(); drive(1'b1, 1'b0, 32'h0800_0000); settle();
    chk("tout_next_setup_psel", {61'd0, b_psel}, 64'h2);
    cyc(); m_penable = 1'b1; b_s_pready = 3'b010; settle();
    chk("tout_next_pready", {63'd0, b_pready}, 64'h1);
    chk("tout_next_pslverr", {63'd0, b_pslverr}, 64'd0);
    chk("tout_next_prdata", {32'd0, b_prdata}, 64'h7777_0001);
`endif

    cyc(); drive(1'b0, 1'b0, 32'h0);
    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/core_apb_dec.md
CORE_APB_DEC -- requirements
Module: core_apb_dec

Interface
REQ-001 Parameter AW, default 32: APB address width.
REQ-002 Parameter DW, default 32: APB data width, multiple of 8.
REQ-003 Parameter NSLV, default 2: slave port count, 1..2**DEC_W.
REQ-004 Parameter DEC_LSB, default 27: lowest address bit of the slave-index field.
REQ-005 Parameter DEC_W, default 1: width of the slave-index field m_paddr[DEC_LSB+DEC_W-1:DEC_LSB].
REQ-006 Parameter TOUT_CYC, default 255: maximum wait cycles tolerated in the access phase, >=1.
REQ-007 Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- m_psel, m_penable, m_pwrite  in  1 each  upstream APB controls.
- m_paddr  in  AW  upstream address.
- m_pstrb  in  DW/8  upstream strobes.
- m_pprot  in  3  upstream protection.
- m_pwdata  in  DW  upstream write data.
- m_prdata  out  DW  upstream read data.
- m_pslverr, m_pready  out  1 each  upstream response.
- s_psel, s_penable  out  NSLV  per-slave select and enable.
- s_paddr, s_pwrite, s_pstrb, s_pprot, s_pwdata  out  AW/1/DW/8/3/DW  shared copies of m_* fields.
- s_prdata  in  NSLV*DW  slave i read data at bits [i*DW+:DW].
- s_pslverr, s_pready  in  NSLV  per-slave response.

Function
REQ-008 idx = m_paddr slave-index field; idx >= NSLV SHALL be unmapped.
REQ-009 FSM states IDLE and ACCESS: IDLE->ACCESS on m_psel & ~m_penable; ACCESS->IDLE on any cycle with m_pready=1 or m_psel=0.
REQ-010 On the IDLE->ACCESS edge, idx SHALL be latched into sel_q; in ACCESS, response muxing SHALL use sel_q only.
REQ-011 s_psel[i] SHALL be m_psel & (live idx==i in IDLE, sel_q==i in ACCESS) & ~abort; s_penable[i] SHALL be s_psel[i] & m_penable & (state==ACCESS).
REQ-012 s_paddr/s_pwrite/s_pstrb/s_pprot/s_pwdata SHALL be combinational copies of the m_* fields.
REQ-013 Mapped access cycle: m_pready/m_pslverr/m_prdata SHALL be combinational from slave sel_q, zero added latency.
REQ-014 Unmapped access: no s_psel asserted; first access cycle SHALL return m_pready=1, m_pslverr=1, m_prdata=0.
REQ-015 m_penable=1 while in IDLE (protocol violation): no slave selected; m_pready=1, m_pslverr=1, m_prdata=0 same cycle.
REQ-016 Outside a completing cycle, m_pready=0, m_pslverr=0, m_prdata=0.
REQ-017 Back-to-back transfers (new setup the cycle after completion) SHALL be accepted with no idle cycle.
REQ-018 m_psel dropped in ACCESS SHALL return to IDLE with no response and clear the wait counter.

Reset
REQ-019 While rst=1: state=IDLE, sel_q=0, wait counter=0; s_psel, s_penable, m_pready, m_pslverr, m_prdata forced 0 regardless of inputs.
REQ-020 Reset asserted mid-transfer SHALL abandon it; the first cycle after deassertion starts in IDLE.

Configuration
REQ-021 Macro CORE_APB_DEC_TOUT_EN defined: wait counter of $clog2(TOUT_CYC+1) bits, cleared on IDLE->ACCESS, incremented each ACCESS cycle with m_penable=1 and selected s_pready=0.
REQ-022 With it defined, when the counter equals TOUT_CYC, that cycle SHALL assert abort: s_psel/s_penable of sel_q=0, m_pready=1, m_pslverr=1, m_prdata=0; FSM returns to IDLE.
REQ-023 Macro undefined: no counter or abort logic; an unresponsive slave stalls the master indefinitely.

Verification
REQ-024 Read at 0x0000_0010, slave0 pready=1, prdata=0xA5A5_0001 -> s_psel=2'b01, m_prdata=0xA5A5_0001, m_pready=1 in first access cycle, m_pslverr=0.
REQ-025 Write at 0x0800_0004, slave1 inserts 3 wait cycles -> s_psel=2'b10, m_pready=1 exactly on 4th access cycle, pwdata/pstrb passed through unchanged.
REQ-026 NSLV=3, DEC_W=2, access idx=3 -> s_psel=0, m_pready=1, m_pslverr=1, m_prdata=0 in first access cycle.
REQ-027 TOUT_EN, TOUT_CYC=4, slave0 pready held 0 -> m_pready=1, m_pslverr=1, s_psel[0]=0 on 5th access cycle; next transfer to slave1 completes normally.
REQ-028 rst pulsed in 2nd wait cycle of a slave1 access -> all outputs 0 during reset; following setup to slave0 completes with m_pslverr=0.
